// File: rtl/blob_topk_sorter.sv
// blob_topk_sorter: scans blob records in shared RAM, keeps the best TOP_K
// under a selectable key. Define BLOB_SORT_COUNT_EN for a kept-blob count word.
module blob_topk_sorter #(
  parameter int ADDR_W    = 18,
  parameter int REC_BASE  = 200000,
  parameter int OUT_BASE  = 200100,
  parameter int TOP_K     = 4,
  parameter int MAX_BLOBS = 1024,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_blob_sorting,
  input  logic              pause,
  input  logic [15:0]       blob_extraction_blob_counter,
  input  logic [7:0]        minimum_blob_size,
  input  logic [1:0]        sort_mode,
  input  logic [31:0]       data_read,
  output logic [ADDR_W-1:0] address,
  output logic              wren,
  output logic [31:0]       data_write,
  output logic              blob_sorting_done
);
`ifdef BLOB_SORT_COUNT_EN
  localparam int NW = 3*TOP_K + 1;
`else
  localparam int NW = 3*TOP_K;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_WAIT, S_EVAL, S_WRITE, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cyc_q, cyc_d;
  logic [15:0]       n_q, n_d, lim_q, lim_d, n_nx;
  logic [1:0]        mode_q, mode_d;
  logic [7:0]        min_q, min_d;
  logic [31:0]       w0_q, w0_d, w1_q, w1_d;
  logic [ADDR_W-1:0] ra_q, ra_d, addr_q, addr_d;
  logic [4:0]        wi_q, wi_d;
  logic [3:0]        ws_q, ws_d;
  logic [1:0]        wj_q, wj_d;
  logic              wren_q, wren_d, done_q, done_d;
  logic [31:0]       dw_q, dw_d;
  logic [TOP_K-1:0]  vld_q, vld_d, better;
  logic [31:0]       s0_q [TOP_K];
  logic [31:0]       s1_q [TOP_K];
  logic [31:0]       s2_q [TOP_K];
  logic [31:0]       s0_d [TOP_K];
  logic [31:0]       s1_d [TOP_K];
  logic [31:0]       s2_d [TOP_K];
  logic [15:0]       key_new;
  logic              keep, is_term, seen, pv;
  logic [31:0]       p0, p1, p2, wr_word;
`ifdef BLOB_SORT_COUNT_EN
  logic [15:0]       kept_q, kept_d;
`endif

  function automatic logic beats(input logic [1:0] m,
                                 input logic [15:0] a,
                                 input logic [15:0] b);
    return (m == 2'd0 || m == 2'd3) ? (a > b) : (a < b);
  endfunction

  // rank the record under evaluation against every held slot
  always_comb begin
    key_new = mode_q[1] ? w1_q[15:0] : w0_q[31:16];
    is_term = (w0_q == 32'hffffffff);
    keep    = !is_term && (w0_q[31:16] >= {8'h0, min_q});
    better  = '0;
    for (int i = 0; i < TOP_K; i++)
      better[i] = !vld_q[i] ||
        beats(mode_q, key_new,
              mode_q[1] ? s1_q[i][15:0] : s0_q[i][31:16]);
  end

  // pick the result word for the current write slot
  always_comb begin
    wr_word = '0;
    for (int i = 0; i < TOP_K; i++)
      if (ws_q == 4'(i) && vld_q[i])
        wr_word = (wj_q == 2'd0) ? s0_q[i] :
                  (wj_q == 2'd1) ? s1_q[i] : s2_q[i];
`ifdef BLOB_SORT_COUNT_EN
    if (ws_q == 4'(TOP_K)) wr_word = {16'h0, kept_q};
`endif
  end

  // next-state, RAM port and ranked-slot update
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    n_d     = n_q;
    lim_d   = lim_q;
    mode_d  = mode_q;
    min_d   = min_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    ra_d    = ra_q;
    wi_d    = wi_q;
    ws_d    = ws_q;
    wj_d    = wj_q;
    vld_d   = vld_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    addr_d  = addr_q;
    wren_d  = 1'b0;
    dw_d    = dw_q;
    done_d  = 1'b0;
    seen    = 1'b0;
    pv      = 1'b0;
    p0      = '0;
    p1      = '0;
    p2      = '0;
`ifdef BLOB_SORT_COUNT_EN
    kept_d  = kept_q;
`endif
    n_nx    = n_q + 16'd1;
    if ((state_q == S_FETCH || state_q == S_WAIT) &&
        cyc_q == 3'(1 + RD_LAT))
      w0_d = data_read;
    if ((state_q == S_FETCH || state_q == S_WAIT) &&
        cyc_q == 3'(2 + RD_LAT))
      w1_d = data_read;
    unique case (state_q)
      S_IDLE: if (enable_blob_sorting) begin
        mode_d  = sort_mode;
        min_d   = minimum_blob_size;
        lim_d   = blob_extraction_blob_counter;
        state_d = S_CLEAR;
      end
      S_CLEAR: begin
        vld_d   = '0;
        n_d     = '0;
        cyc_d   = '0;
        ra_d    = ADDR_W'(REC_BASE);
        wi_d    = '0;
        ws_d    = '0;
        wj_d    = '0;
`ifdef BLOB_SORT_COUNT_EN
        kept_d  = '0;
`endif
        state_d = (lim_q == 16'd0) ? S_WRITE : S_FETCH;
      end
      S_FETCH: if (!(cyc_q == 3'd0 && pause)) begin
        addr_d = ra_q + ADDR_W'(cyc_q);
        cyc_d  = cyc_q + 3'd1;
        if (cyc_q == 3'd2) state_d = S_WAIT;
      end
      S_WAIT: begin
        cyc_d = cyc_q + 3'd1;
        if (cyc_q == 3'(2 + RD_LAT)) state_d = S_EVAL;
      end
      S_EVAL: begin
        if (keep) begin
          for (int i = 0; i < TOP_K; i++) begin
            if (seen) begin
              vld_d[i] = pv;
              s0_d[i]  = p0;
              s1_d[i]  = p1;
              s2_d[i]  = p2;
            end else if (better[i]) begin
              vld_d[i] = 1'b1;
              s0_d[i]  = w0_q;
              s1_d[i]  = w1_q;
              s2_d[i]  = data_read;
              seen     = 1'b1;
            end
            pv = vld_q[i];
            p0 = s0_q[i];
            p1 = s1_q[i];
            p2 = s2_q[i];
          end
`ifdef BLOB_SORT_COUNT_EN
          if (kept_q != 16'hffff) kept_d = kept_q + 16'd1;
`endif
        end
        cyc_d = '0;
        n_d   = n_nx;
        ra_d  = ra_q + ADDR_W'(3);
        if (is_term || n_nx == lim_q || n_nx == 16'(MAX_BLOBS))
          state_d = S_WRITE;
        else
          state_d = S_FETCH;
      end
      S_WRITE: if (!pause) begin
        wren_d = 1'b1;
        addr_d = ADDR_W'(OUT_BASE) + ADDR_W'(wi_q);
        dw_d   = wr_word;
        wi_d   = wi_q + 5'd1;
        if (wj_q == 2'd2) begin
          wj_d = '0;
          ws_d = ws_q + 4'd1;
        end else begin
          wj_d = wj_q + 2'd1;
        end
        if (wi_q == 5'(NW - 1)) state_d = S_DONE;
      end
      S_DONE: done_d = 1'b1;
      default: state_d = S_IDLE;
    endcase
    if (!enable_blob_sorting) begin
      state_d = S_IDLE;
      wren_d  = 1'b0;
      done_d  = 1'b0;
      addr_d  = addr_q;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      n_q     <= '0;
      lim_q   <= '0;
      mode_q  <= '0;
      min_q   <= '0;
      w0_q    <= '0;
      w1_q    <= '0;
      ra_q    <= '0;
      wi_q    <= '0;
      ws_q    <= '0;
      wj_q    <= '0;
      vld_q   <= '0;
      addr_q  <= '0;
      wren_q  <= 1'b0;
      dw_q    <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < TOP_K; i++) begin
        s0_q[i] <= '0;
        s1_q[i] <= '0;
        s2_q[i] <= '0;
      end
`ifdef BLOB_SORT_COUNT_EN
      kept_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      n_q     <= n_d;
      lim_q   <= lim_d;
      mode_q  <= mode_d;
      min_q   <= min_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      ra_q    <= ra_d;
      wi_q    <= wi_d;
      ws_q    <= ws_d;
      wj_q    <= wj_d;
      vld_q   <= vld_d;
      addr_q  <= addr_d;
      wren_q  <= wren_d;
      dw_q    <= dw_d;
      done_q  <= done_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
`ifdef BLOB_SORT_COUNT_EN
      kept_q  <= kept_d;
`endif
    end
  end

  assign address           = addr_q;
  assign wren              = wren_q;
  assign data_write        = dw_q;
  assign blob_sorting_done = done_q;

endmodule

// File: tb/tb_blob_topk_sorter.sv
// tb_blob_topk_sorter: directed and random passes checked against a
// filter-then-pick-best model of the ranked result table.
`timescale 1ns/1ps
module tb_blob_topk_sorter;
  localparam int AW   = 18;
  localparam int RB   = 200000;
  localparam int OB   = 200100;
  localparam int K    = 3;
  localparam int MAXB = 16;
  localparam int LAT  = 2;
  localparam int NREC = 20;
`ifdef BLOB_SORT_COUNT_EN
  localparam int NW = 3*K + 1;
`else
  localparam int NW = 3*K;
`endif

  logic          clk = 1'b0;
  logic          reset, enable_blob_sorting, pause;
  logic [15:0]   blob_extraction_blob_counter;
  logic [7:0]    minimum_blob_size;
  logic [1:0]    sort_mode;
  logic [31:0]   data_read;
  logic [AW-1:0] address;
  logic          wren;
  logic [31:0]   data_write;
  logic          blob_sorting_done;

  blob_topk_sorter #(
    .ADDR_W(AW), .REC_BASE(RB), .OUT_BASE(OB),
    .TOP_K(K), .MAX_BLOBS(MAXB), .RD_LAT(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable_blob_sorting(enable_blob_sorting),
    .pause(pause),
    .blob_extraction_blob_counter(blob_extraction_blob_counter),
    .minimum_blob_size(minimum_blob_size),
    .sort_mode(sort_mode),
    .data_read(data_read),
    .address(address),
    .wren(wren),
    .data_write(data_write),
    .blob_sorting_done(blob_sorting_done)
  );

  always #5 clk = ~clk;

  logic [31:0] recm [0:3*NREC-1];
  logic [31:0] outm [0:NW];
  logic [31:0] rp [LAT];
  logic        clr_out = 1'b0;
  int          nwr = 0;
  int          nbad = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ew [0:NW-1];
  int          en_eval;
  int          ekept;

  // RAM model: registered read pipeline plus result-table capture
  always @(posedge clk) begin
    int ai, ri;
    ai = int'(address) - OB;
    ri = int'(address) - RB;
    if (clr_out) begin
      for (int i = 0; i <= NW; i++) outm[i] <= 32'hdeadbeef;
      nwr  <= 0;
      nbad <= 0;
    end else if (wren) begin
      nwr <= nwr + 1;
      if (ai >= 0 && ai <= NW) outm[ai] <= data_write;
      else nbad <= nbad + 1;
    end
    rp[0] <= (ri >= 0 && ri < 3*NREC) ? recm[ri] : 32'h0;
    for (int i = 1; i < LAT; i++) rp[i] <= rp[i-1];
  end
  assign data_read = rp[LAT-1];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_rec(input int r, input int sz, input int y);
    recm[3*r]   = {16'(sz), 16'hc000 + 16'(r)};
    recm[3*r+1] = {16'h0100 + 16'(r), 16'(y)};
    recm[3*r+2] = 32'hb0b00000 + 32'(r);
  endtask

  task automatic rand_recs(input bit term);
    for (int r = 0; r < NREC; r++) begin
      set_rec(r, 4*$urandom_range(0, 15), 3*$urandom_range(0, 15));
      if (term && $urandom_range(0, 11) == 0) recm[3*r] = 32'hffffffff;
    end
  endtask

  function automatic logic wins(input logic [1:0] m, input int a,
                                input int b);
    logic [31:0] wa0, wb0, wa1, wb1;
    wa0 = recm[3*a];
    wb0 = recm[3*b];
    wa1 = recm[3*a+1];
    wb1 = recm[3*b+1];
    case (m)
      2'd0:    return wa0[31:16] > wb0[31:16];
      2'd1:    return wa0[31:16] < wb0[31:16];
      2'd2:    return wa1[15:0] < wb1[15:0];
      default: return wa1[15:0] > wb1[15:0];
    endcase
  endfunction

  task automatic model(input int cnt, input logic [7:0] mn,
                       input logic [1:0] m);
    int cand[$];
    int b;
    logic [31:0] w;
    en_eval = 0;
    for (int r = 0; r < MAXB && r < cnt; r++) begin
      en_eval++;
      w = recm[3*r];
      if (w == 32'hffffffff) break;
      if (w[31:16] >= {8'h0, mn}) cand.push_back(r);
    end
    ekept = cand.size();
    for (int s = 0; s < K; s++) begin
      for (int j = 0; j < 3; j++) ew[3*s+j] = '0;
      if (cand.size() > 0) begin
        b = 0;
        for (int j = 1; j < cand.size(); j++)
          if (wins(m, cand[j], cand[b])) b = j;
        for (int j = 0; j < 3; j++) ew[3*s+j] = recm[3*cand[b]+j];
        cand.delete(b);
      end
    end
`ifdef BLOB_SORT_COUNT_EN
    ew[NW-1] = {16'h0, 16'(ekept)};
`endif
  endtask

  task automatic start(input int cnt, input logic [7:0] mn,
                       input logic [1:0] m);
    @(negedge clk);
    clr_out = 1'b1;
    @(negedge clk);
    clr_out = 1'b0;
    blob_extraction_blob_counter = 16'(cnt);
    minimum_blob_size = mn;
    sort_mode = m;
    enable_blob_sorting = 1'b1;
  endtask

  task automatic run_pass(input string nm, input int cnt,
                          input logic [7:0] mn, input logic [1:0] m,
                          input int pm);
    int lat;
    bit got, held;
    logic [AW-1:0] ah;
    model(cnt, mn, m);
    start(cnt, mn, m);
    lat = 0;
    got = 1'b0;
    held = 1'b0;
    while (!got && lat < 3000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (blob_sorting_done) got = 1'b1;
      else if (pm == 1) pause = ($urandom_range(0, 2) == 0);
      else if (pm == 2 && !held && wren) begin
        held = 1'b1;
        pause = 1'b1;
        ah = address;
        repeat (10) begin
          @(posedge clk);
          lat++;
          @(negedge clk);
          chk({nm, "_pwren"}, 32'(wren), 32'd0);
          chk({nm, "_paddr"}, 32'(address), 32'(ah));
        end
        pause = 1'b0;
      end
    end
    pause = 1'b0;
    chk({nm, "_done"}, 32'(got), 32'd1);
    if (pm == 0)
      chk({nm, "_lat"}, 32'(lat), 32'(2 + en_eval*(4+LAT) + NW + 1));
    chk({nm, "_nwr"}, 32'(nwr), 32'(NW));
    chk({nm, "_nbad"}, 32'(nbad), 32'd0);
    for (int i = 0; i < NW; i++)
      chk($sformatf("%s_w%0d", nm, i), outm[i], ew[i]);
    chk({nm, "_over"}, outm[NW], 32'hdeadbeef);
    enable_blob_sorting = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_dlow"}, 32'(blob_sorting_done), 32'd0);
    chk({nm, "_wlow"}, 32'(wren), 32'd0);
  endtask

  initial begin
    int n0;
    reset = 1'b1;
    enable_blob_sorting = 1'b0;
    pause = 1'b0;
    blob_extraction_blob_counter = '0;
    minimum_blob_size = '0;
    sort_mode = '0;
    for (int i = 0; i < 3*NREC; i++) recm[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_addr", 32'(address), 32'd0);
    chk("rst_wren", 32'(wren), 32'd0);
    chk("rst_dw", data_write, 32'd0);
    chk("rst_done", 32'(blob_sorting_done), 32'd0);
    reset = 1'b0;

    rand_recs(1'b0);
    set_rec(0, 16'h10, 16'h30);
    set_rec(1, 16'h40, 16'h10);
    set_rec(2, 16'h20, 16'h20);
    run_pass("m0", 3, 8'h00, 2'd0, 0);
    chk("m0_s0", outm[0], 32'h0040c001);
    chk("m0_s1", outm[3], 32'h0020c002);
    run_pass("m2", 3, 8'h00, 2'd2, 0);
    run_pass("m3", 3, 8'h00, 2'd3, 0);
    chk("m3_s0", outm[0], 32'h0010c000);
    run_pass("m1min", 3, 8'h30, 2'd1, 0);
    chk("m1min_s1", outm[3], 32'h0);

    recm[3] = 32'hffffffff;
    run_pass("term", 12, 8'h00, 2'd0, 0);
    chk("term_eval", 32'(en_eval), 32'd2);
    run_pass("cnt0", 0, 8'h00, 2'd0, 0);

    set_rec(0, 16'h20, 16'h05);
    set_rec(1, 16'h20, 16'h06);
    set_rec(2, 16'h08, 16'h07);
    run_pass("tie", 3, 8'h00, 2'd0, 0);
    chk("tie_s0", outm[0], 32'h0020c000);

    rand_recs(1'b0);
    run_pass("maxb", 30, 8'h00, 2'd1, 0);
    run_pass("phold", 5, 8'h04, 2'd0, 2);

    start(5, 8'h00, 2'd0);
    repeat (4) @(negedge clk);
    enable_blob_sorting = 1'b0;
    n0 = nwr;
    @(negedge clk);
    chk("abort_wren", 32'(wren), 32'd0);
    chk("abort_done", 32'(blob_sorting_done), 32'd0);
    repeat (30) @(negedge clk);
    chk("abort_nwr", 32'(nwr), 32'(n0));

    start(3, 8'h00, 2'd0);
    repeat (40) @(negedge clk);
    chk("pre_rst_done", 32'(blob_sorting_done), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_addr", 32'(address), 32'd0);
    chk("mid_rst_dw", data_write, 32'd0);
    chk("mid_rst_done", 32'(blob_sorting_done), 32'd0);
    enable_blob_sorting = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    for (int t = 0; t < 25; t++) begin
      rand_recs(1'b1);
      run_pass($sformatf("rnd%0d", t), $urandom_range(0, 20),
               8'(4*$urandom_range(0, 12)), 2'($urandom_range(0, 3)),
               $urandom_range(0, 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
